// File: rtl/input_port_buffer.sv
// input_port_buffer: router input FIFO with route-request FSM and crossbar handoff.
// Optional feature macro IBUF_ERR_FLAG_EN adds a sticky err_o protocol-error flag.
module input_port_buffer #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [FLIT_W-1:0]       in_flit_i,
    input  logic [1:0]              in_type_i,
    output logic [7:0]              hdr_addr_o,
    input  logic [2:0]              route_dir_i,
    output logic                    req_o,
    output logic [2:0]              req_dir_o,
    input  logic                    grant_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [FLIT_W-1:0]       out_flit_o,
    output logic [1:0]              out_type_o,
`ifdef IBUF_ERR_FLAG_EN
    output logic                    err_o,
`endif
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    logic [FLIT_W-1:0] flit_mem [DEPTH];
    logic [1:0]        type_mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    state_t            state, state_d;
    logic [2:0]        dir_q, dir_d;
    logic              push, pop, empty, xfer_valid;
    logic [FLIT_W-1:0] head_flit;
    logic [1:0]        head_type;

    assign empty      = (count == '0);
    assign head_flit  = flit_mem[rd_ptr];
    assign head_type  = type_mem[rd_ptr];
    // Full is exactly the MSB of the occupancy because DEPTH is a power of two.
    assign in_ready_o = rst_ni && !count[AW];
    assign push       = in_valid_i && in_ready_o;
    assign count_o    = count;
    assign hdr_addr_o = empty ? 8'h00 : head_flit[7:0];
    assign xfer_valid = (state == XFER) && !empty;
    assign out_valid_o = xfer_valid;
    assign out_flit_o = xfer_valid ? head_flit : '0;
    assign out_type_o = xfer_valid ? head_type : 2'b00;
    assign req_dir_o  = req_o ? dir_q : 3'b000;

    // Flit storage written on every accepted upstream beat.
    always_ff @(posedge clk_i) begin
        if (push) begin
            flit_mem[wr_ptr] <= in_flit_i;
            type_mem[wr_ptr] <= in_type_i;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FSM state and latched route direction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            dir_q <= 3'b000;
        end else begin
            state <= state_d;
            dir_q <= dir_d;
        end
    end

    // Next state, request and pop; head/single types have equal type bits, tail/single have bit 1 set.
    always_comb begin
        state_d = state;
        dir_d   = dir_q;
        pop     = 1'b0;
        req_o   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_type[1] == head_type[0]) begin
                        dir_d   = route_dir_i;
                        state_d = REQ;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            REQ: begin
                req_o = 1'b1;
                if (grant_i) state_d = XFER;
            end
            XFER: begin
                req_o = 1'b1;
                pop   = xfer_valid && out_ready_i;
                if (pop && head_type[1]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef IBUF_ERR_FLAG_EN
    logic discard, err_q;
    assign discard = (state == IDLE) && !empty && (head_type[1] != head_type[0]);
    assign err_o   = err_q;

    // Sticky record of any stray body/tail flit dropped while idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_q | discard;
    end
`endif

endmodule

// File: tb/tb_input_port_buffer.sv
// tb_input_port_buffer: directed self-checking bench for input_port_buffer (DEPTH=4, FLIT_W=32).
module tb_input_port_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_flit_i = '0;
    logic [1:0]  in_type_i = 2'b00;
    logic [7:0]  hdr_addr_o;
    logic [2:0]  route_dir_i = 3'b000;
    logic        req_o;
    logic [2:0]  req_dir_o;
    logic        grant_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_flit_o;
    logic [1:0]  out_type_o;
    logic [2:0]  count_o;
`ifdef IBUF_ERR_FLAG_EN
    logic        err_o;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    input_port_buffer #(.DEPTH(4), .FLIT_W(32)) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_flit_i(in_flit_i),
        .in_type_i(in_type_i),
        .hdr_addr_o(hdr_addr_o),
        .route_dir_i(route_dir_i),
        .req_o(req_o),
        .req_dir_o(req_dir_o),
        .grant_i(grant_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_flit_o(out_flit_o),
        .out_type_o(out_type_o),
`ifdef IBUF_ERR_FLAG_EN
        .err_o(err_o),
`endif
        .count_o(count_o)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        tick;
        tick;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_o); end
        checks++; if (req_o !== 1'b0 || req_dir_o !== 3'b000) begin errors++; $display("FAIL reset_req got=%b/%b exp=0/000", req_o, req_dir_o); end
        checks++; if (out_valid_o !== 1'b0 || out_flit_o !== 32'h0 || out_type_o !== 2'b00) begin errors++; $display("FAIL reset_out got=%b/%h/%b exp=0/0/00", out_valid_o, out_flit_o, out_type_o); end
        checks++; if (hdr_addr_o !== 8'h00) begin errors++; $display("FAIL reset_hdr got=%h exp=00", hdr_addr_o); end
`ifdef IBUF_ERR_FLAG_EN
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_o); end
`endif
        rst_ni = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_single;
        in_valid_i = 1'b1; in_type_i = 2'b11; in_flit_i = 32'hDEAD_0023;
        route_dir_i = 3'b011; grant_i = 1'b1; out_ready_i = 1'b1;
        tick;
        in_valid_i = 1'b0;
        checks++; if (count_o !== 3'd1 || hdr_addr_o !== 8'h23 || req_o !== 1'b0) begin errors++; $display("FAIL single_push got=%0d/%h/%b exp=1/23/0", count_o, hdr_addr_o, req_o); end
        tick;
        route_dir_i = 3'b000;
        checks++; if (req_o !== 1'b1 || req_dir_o !== 3'b011 || out_valid_o !== 1'b0) begin errors++; $display("FAIL single_req got=%b/%b/%b exp=1/011/0", req_o, req_dir_o, out_valid_o); end
        tick;
        checks++; if (out_valid_o !== 1'b1 || out_flit_o !== 32'hDEAD_0023 || out_type_o !== 2'b11 || req_dir_o !== 3'b011) begin errors++; $display("FAIL single_beat got=%b/%h/%b/%b exp=1/dead0023/11/011", out_valid_o, out_flit_o, out_type_o, req_dir_o); end
        tick;
        checks++; if (out_valid_o !== 1'b0 || req_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL single_done got=%b/%b/%0d exp=0/0/0", out_valid_o, req_o, count_o); end
        grant_i = 1'b0; out_ready_i = 1'b0;
    endtask

    task automatic test_full;
        logic [31:0] f [5];
        logic [1:0]  t [5];
        int idx;
        logic acc;
        for (int i = 0; i < 5; i++) begin
            f[i] = 32'h0000_00A0 + i;
            t[i] = (i == 0) ? 2'b00 : (i == 4) ? 2'b10 : 2'b01;
        end
        grant_i = 1'b0; out_ready_i = 1'b0; route_dir_i = 3'b010;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_flit_i = f[i]; in_type_i = t[i];
            tick;
        end
        in_flit_i = f[4]; in_type_i = t[4];
        tick;
        tick;
        checks++; if (count_o !== 3'd4 || in_ready_o !== 1'b0) begin errors++; $display("FAIL full_hold got=%0d/%b exp=4/0", count_o, in_ready_o); end
        checks++; if (req_o !== 1'b1 || req_dir_o !== 3'b010 || out_valid_o !== 1'b0) begin errors++; $display("FAIL full_req got=%b/%b/%b exp=1/010/0", req_o, req_dir_o, out_valid_o); end
        grant_i = 1'b1; out_ready_i = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 5; cyc++) begin
            acc = in_valid_i && in_ready_o;
            if (out_valid_o) begin
                checks++; if (out_flit_o !== f[idx] || out_type_o !== t[idx]) begin errors++; $display("FAIL full_beat%0d got=%h/%b exp=%h/%b", idx, out_flit_o, out_type_o, f[idx], t[idx]); end
                idx++;
            end
            tick;
            if (acc) in_valid_i = 1'b0;
        end
        checks++; if (idx !== 5) begin errors++; $display("FAIL full_beats got=%0d exp=5", idx); end
        checks++; if (req_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL full_done got=%b/%0d exp=0/0", req_o, count_o); end
        in_valid_i = 1'b0; grant_i = 1'b0; out_ready_i = 1'b0;
    endtask

    task automatic test_grant_delay;
        logic [31:0] g [4];
        logic [1:0]  t [4];
        int idx;
        for (int i = 0; i < 4; i++) begin
            g[i] = 32'h0C00_0031 + (i << 8);
            t[i] = (i == 0) ? 2'b00 : (i == 3) ? 2'b10 : 2'b01;
        end
        grant_i = 1'b0; out_ready_i = 1'b1; route_dir_i = 3'b001;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_flit_i = g[i]; in_type_i = t[i];
            tick;
            checks++; if (req_o !== (i > 0) || out_valid_o !== 1'b0) begin errors++; $display("FAIL gd_wait%0d got=%b/%b exp=%b/0", i, req_o, out_valid_o, (i > 0)); end
        end
        in_valid_i = 1'b0;
        checks++; if (count_o !== 3'd4 || req_dir_o !== 3'b001 || hdr_addr_o !== 8'h31) begin errors++; $display("FAIL gd_queued got=%0d/%b/%h exp=4/001/31", count_o, req_dir_o, hdr_addr_o); end
        grant_i = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            if (out_valid_o) begin
                checks++; if (out_flit_o !== g[idx] || out_type_o !== t[idx] || req_o !== 1'b1) begin errors++; $display("FAIL gd_beat%0d got=%h/%b/%b exp=%h/%b/1", idx, out_flit_o, out_type_o, req_o, g[idx], t[idx]); end
                idx++;
            end
            tick;
        end
        checks++; if (idx !== 4 || req_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL gd_done got=%0d/%b/%0d exp=4/0/0", idx, req_o, count_o); end
        grant_i = 1'b0; out_ready_i = 1'b0;
    endtask

    task automatic test_ready_toggle;
        logic [31:0] h [3];
        logic [1:0]  t [3];
        logic [2:0]  cnt;
        logic        beat;
        int idx;
        for (int i = 0; i < 3; i++) begin
            h[i] = 32'h5500_0041 + (i << 12);
            t[i] = (i == 0) ? 2'b00 : (i == 2) ? 2'b10 : 2'b01;
        end
        grant_i = 1'b1; out_ready_i = 1'b0; route_dir_i = 3'b000;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; in_flit_i = h[i]; in_type_i = t[i];
            tick;
        end
        in_valid_i = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            out_ready_i = (cyc % 2 == 1);
            cnt = count_o;
            beat = out_valid_o && out_ready_i;
            if (beat) begin
                checks++; if (out_flit_o !== h[idx] || out_type_o !== t[idx]) begin errors++; $display("FAIL rt_beat%0d got=%h/%b exp=%h/%b", idx, out_flit_o, out_type_o, h[idx], t[idx]); end
                idx++;
            end
            tick;
            checks++; if (count_o !== cnt - {2'b00, beat}) begin errors++; $display("FAIL rt_count%0d got=%0d exp=%0d", cyc, count_o, cnt - {2'b00, beat}); end
        end
        out_ready_i = 1'b0;
        checks++; if (idx !== 3 || req_o !== 1'b0) begin errors++; $display("FAIL rt_done got=%0d/%b exp=3/0", idx, req_o); end
        grant_i = 1'b0;
    endtask

    task automatic test_discard;
        rst_ni = 1'b0;
        tick;
        rst_ni = 1'b1;
        tick;
        grant_i = 1'b1; out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_type_i = 2'b01; in_flit_i = 32'h0000_0077;
        tick;
        in_valid_i = 1'b0;
        checks++; if (count_o !== 3'd1 || req_o !== 1'b0) begin errors++; $display("FAIL disc_push got=%0d/%b exp=1/0", count_o, req_o); end
        tick;
        checks++; if (count_o !== 3'd0 || req_o !== 1'b0) begin errors++; $display("FAIL disc_drop got=%0d/%b exp=0/0", count_o, req_o); end
        tick;
        checks++; if (req_o !== 1'b0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL disc_idle got=%b/%b exp=0/0", req_o, out_valid_o); end
`ifdef IBUF_ERR_FLAG_EN
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL disc_err got=%b exp=1", err_o); end
`endif
        grant_i = 1'b0; out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        grant_i = 1'b0; out_ready_i = 1'b1; route_dir_i = 3'b010;
        in_valid_i = 1'b1; in_type_i = 2'b00; in_flit_i = 32'h0000_0011;
        tick;
        in_type_i = 2'b01; in_flit_i = 32'h0000_0012;
        tick;
        in_flit_i = 32'h0000_0013;
        checks++; if (count_o !== 3'd2 || req_o !== 1'b1) begin errors++; $display("FAIL rm_pre got=%0d/%b exp=2/1", count_o, req_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || in_ready_o !== 1'b0 || hdr_addr_o !== 8'h00) begin errors++; $display("FAIL rm_fifo got=%0d/%b/%h exp=0/0/00", count_o, in_ready_o, hdr_addr_o); end
        checks++; if (req_o !== 1'b0 || req_dir_o !== 3'b000 || out_valid_o !== 1'b0 || out_flit_o !== 32'h0 || out_type_o !== 2'b00) begin errors++; $display("FAIL rm_out got=%b/%b/%b/%h/%b exp=0/000/0/0/00", req_o, req_dir_o, out_valid_o, out_flit_o, out_type_o); end
`ifdef IBUF_ERR_FLAG_EN
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rm_err got=%b exp=0", err_o); end
`endif
        in_valid_i = 1'b0;
        tick;
        rst_ni = 1'b1;
        tick;
        in_valid_i = 1'b1; in_type_i = 2'b11; in_flit_i = 32'h0000_003D;
        route_dir_i = 3'b100; grant_i = 1'b1;
        tick;
        in_valid_i = 1'b0;
        checks++; if (hdr_addr_o !== 8'h3D || count_o !== 3'd1) begin errors++; $display("FAIL rm_new_hdr got=%h/%0d exp=3d/1", hdr_addr_o, count_o); end
        tick;
        checks++; if (req_o !== 1'b1 || req_dir_o !== 3'b100) begin errors++; $display("FAIL rm_new_req got=%b/%b exp=1/100", req_o, req_dir_o); end
        tick;
        checks++; if (out_valid_o !== 1'b1 || out_flit_o !== 32'h0000_003D || out_type_o !== 2'b11) begin errors++; $display("FAIL rm_new_beat got=%b/%h/%b exp=1/3d/11", out_valid_o, out_flit_o, out_type_o); end
        tick;
        checks++; if (req_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL rm_new_done got=%b/%0d exp=0/0", req_o, count_o); end
        grant_i = 1'b0; out_ready_i = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_full;
        test_grant_delay;
        test_ready_toggle;
        test_discard;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_port_buffer.md
INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in flits (power of 2, at least 2).
REQ-002 SHALL have parameter FLIT_W, default 32, flit payload width; bits [7:0] of a head flit hold the destination YX address.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1), in_flit_i (input, FLIT_W) and in_type_i (input, 2), forming the upstream link; in_type_i encodes 00 head, 01 body, 10 tail, 11 single.
REQ-006 SHALL have port hdr_addr_o, output, 8, destination address of the FIFO-head flit, driven to the route-compute stage.
REQ-007 SHALL have port route_dir_i, input, 3, combinational direction returned by route compute: 000 N, 001 S, 010 W, 011 E, 100 local.
REQ-008 SHALL have ports req_o (output, 1), req_dir_o (output, 3) and grant_i (input, 1), forming the switch-arbiter request interface.
REQ-009 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_flit_o (output, FLIT_W) and out_type_o (output, 2), forming the crossbar-side link.
REQ-010 SHALL have port count_o, output, $clog2(DEPTH)+1, current FIFO occupancy.

Function
REQ-011 SHALL push on a cycle where in_valid_i and in_ready_o are both high; in_ready_o = (count_o < DEPTH), so there is no push when full, even on a simultaneous pop.
REQ-012 SHALL wrap read and write pointers modulo DEPTH; a simultaneous push and pop leaves count_o unchanged.
REQ-013 SHALL drive hdr_addr_o = head flit [7:0] when the FIFO is non-empty, and 8'h00 when empty.
REQ-014 SHALL implement FSM states IDLE, REQ, XFER.
REQ-015 IDLE: when the FIFO is non-empty and the head type is head or single, SHALL register route_dir_i into the direction register and go to REQ.
REQ-016 REQ: SHALL hold req_o=1 with req_dir_o = direction register; go to XFER on the cycle after grant_i is sampled high; req_o stays 1 throughout XFER (packet lock).
REQ-017 XFER: out_valid_o = FIFO non-empty, and out_flit_o/out_type_o show the head entry; SHALL pop on out_valid_o && out_ready_i.
REQ-018 XFER: popping a tail or single flit SHALL return the FSM to IDLE with req_o=0 on the next cycle.
REQ-019 out_valid_o SHALL be 0 in IDLE and REQ.
REQ-020 IDLE with a body or tail flit at the head is a protocol error: SHALL pop and discard that flit, with no request issued.
REQ-021 Latency: a head written into an empty FIFO at edge N SHALL give req_o=1 in the cycle after edge N+1; with grant_i high in that cycle, out_valid_o=1 in the cycle after the following edge.
REQ-022 An empty FIFO in XFER (starvation mid-packet) SHALL hold XFER with out_valid_o=0 until more flits arrive.

Reset
REQ-023 rst_ni low SHALL asynchronously clear pointers, count_o=0, FSM=IDLE, direction register=000, err_o=0.
REQ-024 During reset: in_ready_o=0, req_o=0, req_dir_o=000, out_valid_o=0, out_flit_o=0, out_type_o=00, hdr_addr_o=00.
REQ-025 Reset asserted mid-packet SHALL drop all buffered flits; after release the first accepted flit is treated as a new packet.

Configuration
REQ-026 Macro IBUF_ERR_FLAG_EN defined: SHALL add output err_o (1 bit), set sticky on any REQ-020 discard and cleared only by reset.
REQ-027 Macro IBUF_ERR_FLAG_EN undefined: err_o SHALL be absent; the REQ-020 discard behaviour is unchanged.

Verification
REQ-028 Single flit, type 11, flit[7:0]=8'h23, route_dir_i=011, grant_i=1 -> req_o with req_dir_o=011, one out beat of 8'h23, FSM back in IDLE, count_o=0.
REQ-029 Push 5 flits with DEPTH=4 and no grant -> count_o=4, in_ready_o=0, fifth flit held by upstream, nothing lost.
REQ-030 Head/body/body/tail packet, grant_i delayed 3 cycles -> req_o high 3 cycles before any output, then 4 beats in order with req_o continuously high until the tail.
REQ-031 out_ready_i toggled 1/0 during XFER -> pop only on ready cycles; flit order and types preserved.
REQ-032 Body flit as first flit after reset -> discarded, req_o stays 0, err_o=1 when IBUF_ERR_FLAG_EN is defined.
REQ-033 rst_ni pulsed low after the second of four flits -> outputs at reset values immediately, count_o=0, next head packet routed normally.
